// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MEM-stage load/store controller driving a single-port,
// handshaked data memory. Handles lane placement for stores, lane selection
// and extension for loads, misalignment rejection and transaction timeout.
module dm_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    // One spare bit above TIMEOUT-1 so the saturated count can never
    // match the expiry value a second time.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic            we_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [1:0]      lane_q;
    logic            mis;
    logic            accept;
    logic            timed_out;
    logic            to_hit;
    logic [3:0]      be_n;
    logic [31:0]     wdata_n;

    // Load formatting: pick the addressed lane, then sign/zero extend.
    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        if (size == 2'b00)
            fmt_load = {{24{b[7] & ~uns}}, b};
        else if (size == 2'b01)
            fmt_load = {{16{h[15] & ~uns}}, h};
        else
            fmt_load = w;
    endfunction

    // Misalignment and store lane placement, decoded straight from the request.
    always_comb begin
        mis     = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
        be_n    = 4'b1111;
        wdata_n = req_wdata;
        if (req_we) begin
            case (req_size)
                2'b00: begin
                    be_n    = 4'b0001 << req_addr[1:0];
                    wdata_n = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    be_n    = req_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_n = {2{req_wdata[15:0]}};
                end
                default: begin
                    be_n    = 4'b1111;
                    wdata_n = req_wdata;
                end
            endcase
        end
    end

    assign accept    = req_valid && !mis;
    assign timed_out = (TIMEOUT > 0) && (cnt == CW'(TIMEOUT - 1));

    // Next state; a handshake in the expiry cycle wins over the timeout.
    always_comb begin
        state_n = state;
        to_hit  = 1'b0;
        case (state)
            IDLE: if (accept) state_n = REQ;
            REQ: begin
                if (mem_ready)      state_n = we_q ? DONE : RESP;
                else if (timed_out) begin state_n = DONE; to_hit = 1'b1; end
            end
            RESP: begin
                if (mem_rvalid)     state_n = DONE;
                else if (timed_out) begin state_n = DONE; to_hit = 1'b1; end
            end
            default: state_n = IDLE;
        endcase
    end

    // Combinational outputs are forced low while reset is held.
    always_comb begin
        stall    = rst_n && ((state == IDLE && accept) || state == REQ || state == RESP);
        misalign = rst_n && state == IDLE && req_valid && mis;
        mem_req  = (state == REQ);
    end

    // State, timeout counter, latched request and completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            lane_q    <= 2'b00;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            ld_valid  <= 1'b0;
            ld_data   <= '0;
            bus_err   <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE)
                cnt <= '0;
            else if ((state == REQ || state == RESP) && cnt != '1)
                cnt <= cnt + 1'b1;
            if (state == IDLE && accept) begin
                we_q      <= req_we;
                size_q    <= req_size;
                uns_q     <= req_unsigned;
                lane_q    <= req_addr[1:0];
                mem_we    <= req_we;
                mem_addr  <= {req_addr[31:2], 2'b00};
                mem_be    <= be_n;
                mem_wdata <= wdata_n;
            end
            ld_valid <= (state == REQ || state == RESP) && state_n == DONE && !we_q;
            bus_err  <= to_hit;
            if (to_hit && !we_q)
                ld_data <= '0;
            else if (state == RESP && mem_rvalid)
                ld_data <= fmt_load(mem_rdata, lane_q, size_q, uns_q);
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: stimulus pushes expected memory
// requests and completion pulses; a negedge monitor pops and compares.
module tb_dm_access_ctrl;

    localparam int TO    = 4;
    localparam int STUCK = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        stall, ld_valid, misalign, bus_err, mem_req, mem_we;
    logic [31:0] ld_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h5A5A_5A5A;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mexp_t;

    typedef struct packed {
        logic        ldv;
        logic        mis;
        logic        berr;
        logic [31:0] data;
    } cexp_t;

    mexp_t mq[$];
    cexp_t cq[$];
    int    nchk = 0, nerr = 0, stall_cnt = 0;

    dm_access_ctrl #(.TIMEOUT(TO)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
        .misalign(misalign), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: memory-side request contents every REQ cycle, completion pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall) stall_cnt++;
            if (mem_req) begin
                if (mq.size() == 0) begin
                    check("mem_req_unexpected", mem_req, 1'b0);
                end else begin
                    check("mem_fields",
                          {mem_we, mem_addr, mem_be, mq[0].we ? mem_wdata : 32'h0},
                          {mq[0].we, mq[0].addr, mq[0].be, mq[0].we ? mq[0].wdata : 32'h0});
                    if (mem_ready) void'(mq.pop_front());
                end
            end
            if (ld_valid || misalign || bus_err) begin
                if (cq.size() == 0) begin
                    check("pulse_unexpected", {ld_valid, misalign, bus_err}, 3'b000);
                end else begin
                    check("completion",
                          {ld_valid, misalign, bus_err, ld_valid ? ld_data : 32'h0},
                          {cq[0].ldv, cq[0].mis, cq[0].berr, cq[0].ldv ? cq[0].data : 32'h0});
                    void'(cq.pop_front());
                end
            end
        end
    end

    // One aligned access with a cycle-driven memory responder.
    task automatic access(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input int rdy_dly, input int rv_dly,
                          input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] eld,
                          input logic eto, input int estall);
        int n, wr, wv;
        mq.push_back(mexp_t'{we, {addr[31:2], 2'b00}, ebe, ewd});
        if (!we)      cq.push_back(cexp_t'{1'b1, 1'b0, eto, eld});
        else if (eto) cq.push_back(cexp_t'{1'b0, 1'b0, 1'b1, 32'h0});
        stall_cnt    = 0;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(posedge clk); #1;
        n = 0; wr = 0; wv = 0;
        while (n < 40) begin
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h5A5A_5A5A;
            if (mem_req) begin
                if (wr == rdy_dly) mem_ready = 1'b1;
                wr++;
            end else if (stall) begin
                if (wv == rv_dly) begin mem_rvalid = 1'b1; mem_rdata = rd; end
                wv++;
            end else begin
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        check({nm, ":hang"}, 32'(n >= 40), 32'd0);
        @(negedge clk); #1;
        check({nm, ":stall_cycles"}, stall_cnt, estall);
        check({nm, ":pulses_seen"}, cq.size(), 0);
        if (rdy_dly >= STUCK && mq.size() > 0) void'(mq.pop_front());
        check({nm, ":mem_accepts"}, mq.size(), 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // A misaligned request: pulse, no stall, never reaches memory.
    task automatic mis_req(input string nm, input logic [1:0] sz, input logic [31:0] addr);
        cq.push_back(cexp_t'{1'b0, 1'b1, 1'b0, 32'h0});
        stall_cnt    = 0;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = sz;
        req_unsigned = 1'b0;
        req_addr     = addr;
        @(negedge clk); #1;
        check({nm, ":stall"}, stall, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check({nm, ":pulses_seen"}, cq.size(), 0);
        check({nm, ":stall_cycles"}, stall_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {stall, ld_valid, ld_data, misalign, bus_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata},
              106'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Byte stores across all four lanes, upper data bits must be dropped.
        for (int i = 0; i < 4; i++)
            access($sformatf("sb%0d", i), 1'b1, 2'b00, 1'b0, 32'h100 + i, 32'h1234_56A5, '0,
                   0, 0, 4'b0001 << i, 32'hA5A5_A5A5, '0, 1'b0, 2);
        access("sh_lo", 1'b1, 2'b01, 1'b0, 32'h100, 32'hFFFF_BEEF, '0, 0, 0, 4'b0011, 32'hBEEF_BEEF, '0, 1'b0, 2);
        access("sh_hi", 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_C0DE, '0, 0, 0, 4'b1100, 32'hC0DE_C0DE, '0, 1'b0, 2);
        access("sw",    1'b1, 2'b10, 1'b0, 32'h104, 32'hDEAD_BEEF, '0, 0, 0, 4'b1111, 32'hDEAD_BEEF, '0, 1'b0, 2);

        // Loads: lane selection and extension.
        access("lb_s",  1'b0, 2'b00, 1'b0, 32'h202, '0, 32'h1280_3456, 0, 0, 4'hF, '0, 32'hFFFF_FF80, 1'b0, 3);
        access("lbu",   1'b0, 2'b00, 1'b1, 32'h202, '0, 32'h1280_3456, 0, 0, 4'hF, '0, 32'h0000_0080, 1'b0, 3);
        access("lb_b3", 1'b0, 2'b00, 1'b0, 32'h203, '0, 32'h1280_3456, 0, 0, 4'hF, '0, 32'h0000_0012, 1'b0, 3);
        access("lh_hi", 1'b0, 2'b01, 1'b0, 32'h202, '0, 32'h1280_3456, 0, 0, 4'hF, '0, 32'h0000_1280, 1'b0, 3);
        access("lh_lo", 1'b0, 2'b01, 1'b0, 32'h200, '0, 32'h1280_F00D, 0, 0, 4'hF, '0, 32'hFFFF_F00D, 1'b0, 3);
        access("lhu",   1'b0, 2'b01, 1'b1, 32'h200, '0, 32'h1280_F00D, 0, 0, 4'hF, '0, 32'h0000_F00D, 1'b0, 3);
        access("lw",    1'b0, 2'b11, 1'b0, 32'h204, '0, 32'h8765_4321, 0, 0, 4'hF, '0, 32'h8765_4321, 1'b0, 3);

        // Misaligned requests.
        mis_req("mis_half", 2'b01, 32'h301);
        mis_req("mis_word", 2'b10, 32'h302);

        // Wait states, including handshakes landing exactly on the expiry cycle.
        access("lw_wait",  1'b0, 2'b10, 1'b0, 32'h208, '0, 32'hCAFE_F00D, 1, 1, 4'hF, '0, 32'hCAFE_F00D, 1'b0, 5);
        access("lw_rv_edge", 1'b0, 2'b10, 1'b0, 32'h20C, '0, 32'h0BAD_CAFE, 0, 2, 4'hF, '0, 32'h0BAD_CAFE, 1'b0, 5);
        access("sw_rdy_edge", 1'b1, 2'b10, 1'b0, 32'h210, 32'h1111_2222, '0, 3, 0, 4'hF, 32'h1111_2222, '0, 1'b0, 5);

        // Timeouts: ready stuck (load and store), rvalid stuck.
        access("lw_to_req",  1'b0, 2'b10, 1'b0, 32'h214, '0, 32'hFFFF_FFFF, STUCK, 0, 4'hF, '0, 32'h0, 1'b1, 5);
        access("sw_to_req",  1'b1, 2'b00, 1'b0, 32'h219, 32'h77, '0, STUCK, 0, 4'b0010, 32'h7777_7777, '0, 1'b1, 5);
        access("lw_to_resp", 1'b0, 2'b10, 1'b0, 32'h218, '0, 32'hFFFF_FFFF, 0, STUCK, 4'hF, '0, 32'h0, 1'b1, 5);

        // Reset during RESP abandons the load.
        mq.push_back(mexp_t'{1'b0, 32'h400, 4'hF, 32'h0});
        cq.push_back(cexp_t'{1'b1, 1'b0, 1'b0, 32'h0});
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h400;
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_in_resp", {mem_req, stall, ld_valid, bus_err, misalign}, 5'b0);
        mq.delete();
        cq.delete();
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        access("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h404, '0, 32'h2468_ACE0, 0, 0, 4'hF, '0, 32'h2468_ACE0, 1'b0, 3);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
